// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
package alu_pkg;

  // Native ALU datapath width.
  localparam int unsigned ALU_N = 8;

  // ALU select encodings the stage's consumers rely on; other codes pass through.
  localparam logic [ALU_N-1:0] SEL_ADD = ALU_N'(0);
  localparam logic [ALU_N-1:0] SEL_SUB = ALU_N'(1);

  // One queued ALU operation.
  typedef struct packed {
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [ALU_N-1:0] sel;
  } alu_op_t;

  // Result slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_issue_stage_op_fifo.sv
// Synchronous FIFO for queued ALU operations.
// The head entry is presented combinationally on dout.
// Pointers wrap naturally because DEPTH is a power of two.
module op_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy tracking; clear beats any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational ALU: buffers operand triples in a FIFO,
// drives the head onto the ALU, and captures the result into a one-entry
// output slot with valid/ready back-pressure.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_a,
  input  logic [N-1:0]            in_b,
  input  logic [N-1:0]            in_sel,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [N-1:0]            alu_s,
  input  logic [N-1:0]            alu_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [N-1:0]            res_data,
  output logic [$clog2(DEPTH):0]  count
);

  slot_state_t      slot_q;
  slot_state_t      slot_d;
  logic [3*N-1:0]   fifo_din;
  logic [3*N-1:0]   fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;
  logic [N-1:0]     head_a;
  logic [N-1:0]     head_b;
  logic [N-1:0]     head_s;

  assign fifo_din                 = {in_a, in_b, in_sel};
  assign {head_a, head_b, head_s} = fifo_dout;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready && !flush;
  assign res_valid = (slot_q == SLOT_FULL);

  // Head is masked while the queue is empty so the ALU never sees stale or X data.
  assign alu_a = fifo_empty ? '0 : head_a;
  assign alu_b = fifo_empty ? '0 : head_b;
  assign alu_s = fifo_empty ? '0 : head_s;

  op_fifo #(
    .WIDTH (3*N),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (issue),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Result slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= SLOT_EMPTY;
    else        slot_q <= slot_d;
  end

  // Issue decision and slot next state; flush overrides everything.
  always_comb begin
    slot_d = slot_q;
    issue  = 1'b0;
    if (flush) begin
      slot_d = SLOT_EMPTY;
    end else begin
      case (slot_q)
        SLOT_EMPTY: begin
          if (!fifo_empty) begin
            issue  = 1'b1;
            slot_d = SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (res_ready) begin
            if (!fifo_empty) begin
              issue  = 1'b1;
              slot_d = SLOT_FULL;
            end else begin
              slot_d = SLOT_EMPTY;
            end
          end
        end
        default: slot_d = SLOT_EMPTY;
      endcase
    end
  end

  // Result capture; data holds whenever nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     res_data <= '0;
    else if (issue) res_data <= alu_out;
  end

endmodule
